led_pattern_ctrl: RTL and testbench

//   Parametrised multi-channel LED driver; next generation of the single-LED blinker.
//   One shared prescaler produces a slow TICK. Each channel runs its own mode: OFF, ON, BLINK, or BURST.

---
 rtl/led_pattern_ctrl.sv | 136 +++++++++++++
 tb/tb_led_pattern_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED driver: a shared prescaler TICK steps each channel's
// OFF / ON / BLINK / BURST pattern; BURST ends with a one-cycle DONE pulse.
module led_pattern_ctrl #(
  parameter  int unsigned NUM_CH   = 4,
  parameter  int unsigned PRESCALE = 50000,
  parameter  int unsigned CNT_W    = 16,
  parameter  int unsigned BURST_W  = 8,
  localparam int unsigned ADDR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                WE,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic [1:0]          MODE,
  input  logic [CNT_W-1:0]    HALF_PERIOD,
  input  logic [BURST_W-1:0]  BURST_CNT,
  output logic [NUM_CH-1:0]   LED,
  output logic [NUM_CH-1:0]   BUSY,
  output logic [NUM_CH-1:0]   DONE
);

  localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_BURST = 2'b11
  } mode_e;

  logic [PS_W-1:0] ps_cnt;
  logic            tick;
  logic            wr_ok;

  mode_e [NUM_CH-1:0]              mode_q,   mode_d;
  logic  [NUM_CH-1:0][CNT_W-1:0]   half_q,   half_d;
  logic  [NUM_CH-1:0][CNT_W-1:0]   phase_q,  phase_d;
  logic  [NUM_CH-1:0][BURST_W-1:0] remain_q, remain_d;
  logic  [NUM_CH-1:0]              led_q,    led_d;
  logic  [NUM_CH-1:0]              busy_q,   busy_d;
  logic  [NUM_CH-1:0]              done_q,   done_d;

  // Shared prescaler: TICK on the last count of each PRESCALE window
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ps_cnt <= '0;
    end else if (ps_cnt == PS_LAST) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  assign tick  = (ps_cnt == PS_LAST);
  assign wr_ok = WE && (32'(ADDR) < NUM_CH);

  // Channel state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i] <= MODE_OFF;
      end
      half_q   <= '0;
      phase_q  <= '0;
      remain_q <= '0;
      led_q    <= '0;
      busy_q   <= '0;
      done_q   <= '0;
    end else begin
      mode_q   <= mode_d;
      half_q   <= half_d;
      phase_q  <= phase_d;
      remain_q <= remain_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Per-channel next state; a write to a channel masks that channel's TICK
  always_comb begin
    mode_d   = mode_q;
    half_d   = half_q;
    phase_d  = phase_q;
    remain_d = remain_q;
    led_d    = led_q;
    busy_d   = busy_q;
    done_d   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_ok && (ADDR == ADDR_W'(i))) begin
        mode_d[i]   = mode_e'(MODE);
        half_d[i]   = (HALF_PERIOD == '0) ? CNT_W'(1) : HALF_PERIOD;
        phase_d[i]  = '0;
        remain_d[i] = BURST_CNT;
        led_d[i]    = 1'b0;
        busy_d[i]   = 1'b0;
        case (mode_e'(MODE))
          MODE_OFF:   led_d[i] = 1'b0;
          MODE_ON:    led_d[i] = 1'b1;
          MODE_BLINK: led_d[i] = 1'b1;
          MODE_BURST: begin
            if (BURST_CNT != '0) begin
              led_d[i]  = 1'b1;
              busy_d[i] = 1'b1;
            end else begin
              done_d[i] = 1'b1;
              mode_d[i] = MODE_OFF;
            end
          end
        endcase
      end else if (tick && ((mode_q[i] == MODE_BLINK) || (mode_q[i] == MODE_BURST))) begin
        if (phase_q[i] == (half_q[i] - CNT_W'(1))) begin
          phase_d[i] = '0;
          led_d[i]   = ~led_q[i];
          // Bursts count falling edges; the last one finishes the burst
          if ((mode_q[i] == MODE_BURST) && led_q[i]) begin
            remain_d[i] = remain_q[i] - BURST_W'(1);
            if (remain_q[i] == BURST_W'(1)) begin
              busy_d[i] = 1'b0;
              done_d[i] = 1'b1;
              mode_d[i] = MODE_OFF;
            end
          end
        end else begin
          phase_d[i] = phase_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign LED  = led_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl (NUM_CH=4, PRESCALE=4) plus a NUM_CH=3
// instance for out-of-range address writes.
module tb_led_pattern_ctrl;

  localparam logic [1:0] M_OFF = 2'b00, M_ON = 2'b01, M_BLINK = 2'b10, M_BURST = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = '0;
  logic [1:0]  mode = '0;
  logic [15:0] half = '0;
  logic [7:0]  bcnt = '0;
  logic [3:0]  led, busy, done;

  logic        we3 = 1'b0;
  logic [1:0]  addr3 = '0;
  logic [1:0]  mode3 = '0;
  logic [15:0] half3 = '0;
  logic [7:0]  bcnt3 = '0;
  logic [2:0]  led3, busy3, done3;

  int n_checks = 0;
  int n_fail   = 0;
  int tb_ps;

  always #5 clk = ~clk;

  // Reference prescaler phase: value 3 means the next rising edge is a TICK
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ps <= 0;
    else        tb_ps <= (tb_ps == 3) ? 0 : tb_ps + 1;
  end

  led_pattern_ctrl #(.NUM_CH(4), .PRESCALE(4), .CNT_W(16), .BURST_W(8)) dut (
    .CLK(clk), .RST_N(rst_n), .WE(we), .ADDR(addr), .MODE(mode),
    .HALF_PERIOD(half), .BURST_CNT(bcnt), .LED(led), .BUSY(busy), .DONE(done)
  );

  led_pattern_ctrl #(.NUM_CH(3), .PRESCALE(4), .CNT_W(16), .BURST_W(8)) dut3 (
    .CLK(clk), .RST_N(rst_n), .WE(we3), .ADDR(addr3), .MODE(mode3),
    .HALF_PERIOD(half3), .BURST_CNT(bcnt3), .LED(led3), .BUSY(busy3), .DONE(done3)
  );

  // Called just after a falling edge; the write is taken on the next rising edge
  task automatic wr(input int ch, input logic [1:0] m, input logic [15:0] h, input logic [7:0] c);
    we = 1'b1; addr = 2'(ch); mode = m; half = h; bcnt = c;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic align();
    for (int k = 0; k < 8 && tb_ps != 3; k++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({led, busy, done} !== 12'h000) begin
      n_fail++; $display("FAIL reset_held got=%h exp=000", {led, busy, done});
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if ({led, busy, done} !== 12'h000) begin
      n_fail++; $display("FAIL reset_idle got=%h exp=000", {led, busy, done});
    end
  endtask

  task automatic test_blink();
    logic [3:0] exp;
    align();
    wr(0, M_BLINK, 16'd2, 8'd0);
    for (int i = 0; i < 24; i++) begin
      exp = {3'b000, ((i / 8) % 2) == 0};
      n_checks++;
      if (led !== exp) begin
        n_fail++; $display("FAIL blink_half2 i=%0d got=%b exp=%b", i, led, exp);
      end
      @(negedge clk);
    end
    wr(0, M_OFF, 16'd0, 8'd0);
    n_checks++;
    if (led !== 4'b0000) begin
      n_fail++; $display("FAIL blink_off got=%b exp=0000", led);
    end
  endtask

  task automatic test_burst();
    logic [2:0] exp;
    align();
    wr(1, M_BURST, 16'd1, 8'd3);
    for (int i = 0; i < 28; i++) begin
      exp = {(i < 20) && (((i / 4) % 2) == 0), i < 20, i == 20};
      n_checks++;
      if ({led[1], busy[1], done[1]} !== exp) begin
        n_fail++; $display("FAIL burst3 i=%0d got=%b exp=%b", i, {led[1], busy[1], done[1]}, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_zero_cfg();
    logic exp;
    align();
    wr(2, M_BLINK, 16'd0, 8'd0);
    for (int i = 0; i < 16; i++) begin
      exp = ((i / 4) % 2) == 0;
      n_checks++;
      if (led[2] !== exp) begin
        n_fail++; $display("FAIL half0 i=%0d got=%b exp=%b", i, led[2], exp);
      end
      @(negedge clk);
    end
    wr(2, M_OFF, 16'd0, 8'd0);
    wr(3, M_BURST, 16'd5, 8'd0);
    n_checks++;
    if ({led[3], busy[3], done[3]} !== 3'b001) begin
      n_fail++; $display("FAIL burst0_pulse got=%b exp=001", {led[3], busy[3], done[3]});
    end
    @(negedge clk);
    n_checks++;
    if ({led[3], busy[3], done[3]} !== 3'b000) begin
      n_fail++; $display("FAIL burst0_after got=%b exp=000", {led[3], busy[3], done[3]});
    end
    repeat (12) @(negedge clk);
    n_checks++;
    if ({led, busy, done} !== 12'h000) begin
      n_fail++; $display("FAIL burst0_idle got=%h exp=000", {led, busy, done});
    end
  endtask

  task automatic test_rewrite();
    logic [2:0] exp;
    align();
    wr(2, M_BURST, 16'd1, 8'd5);
    for (int i = 0; i < 15; i++) begin
      exp = {((i / 4) % 2) == 0, 1'b1, 1'b0};
      n_checks++;
      if ({led[2], busy[2], done[2]} !== exp) begin
        n_fail++; $display("FAIL rewrite_first i=%0d got=%b exp=%b", i, {led[2], busy[2], done[2]}, exp);
      end
      @(negedge clk);
    end
    align();
    wr(2, M_BURST, 16'd1, 8'd2);
    for (int i = 0; i < 16; i++) begin
      exp = {(i < 12) && (((i / 4) % 2) == 0), i < 12, i == 12};
      n_checks++;
      if ({led[2], busy[2], done[2]} !== exp) begin
        n_fail++; $display("FAIL rewrite_second i=%0d got=%b exp=%b", i, {led[2], busy[2], done[2]}, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp;
    align();
    wr(3, M_BLINK, 16'd1, 8'd0);
    wr(0, M_BLINK, 16'd2, 8'd0);
    repeat (4) @(negedge clk);
    align();
    n_checks++;
    if ({led[0], led[3]} !== 2'b10) begin
      n_fail++; $display("FAIL tickwr_pre got=%b exp=10", {led[0], led[3]});
    end
    wr(0, M_BLINK, 16'd2, 8'd0);
    for (int j = 0; j < 16; j++) begin
      exp = {j < 8, ((j / 4) % 2) == 0};
      n_checks++;
      if ({led[0], led[3]} !== exp) begin
        n_fail++; $display("FAIL tickwr j=%0d got=%b exp=%b", j, {led[0], led[3]}, exp);
      end
      @(negedge clk);
    end
    wr(0, M_OFF, 16'd0, 8'd0);
    wr(3, M_OFF, 16'd0, 8'd0);
  endtask

  task automatic test_async_reset();
    align();
    wr(1, M_BURST, 16'd1, 8'd3);
    repeat (8) @(negedge clk);
    wr(3, M_BURST, 16'd1, 8'd0);
    n_checks++;
    if ({led[1], busy[1], done[3]} !== 3'b111) begin
      n_fail++; $display("FAIL arst_pre got=%b exp=111", {led[1], busy[1], done[3]});
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({led, busy, done} !== 12'h000) begin
      n_fail++; $display("FAIL arst_async got=%h exp=000", {led, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if ({led, busy, done} !== 12'h000) begin
      n_fail++; $display("FAIL arst_after got=%h exp=000", {led, busy, done});
    end
  endtask

  task automatic test_addr_range();
    we3 = 1'b1; addr3 = 2'd3; mode3 = M_ON; half3 = 16'd1; bcnt3 = 8'd0;
    @(negedge clk);
    mode3 = M_BURST;
    @(negedge clk);
    we3 = 1'b0;
    n_checks++;
    if ({led3, busy3, done3} !== 9'h000) begin
      n_fail++; $display("FAIL addr_oob got=%h exp=000", {led3, busy3, done3});
    end
    we3 = 1'b1; addr3 = 2'd2; mode3 = M_ON;
    @(negedge clk);
    we3 = 1'b0;
    n_checks++;
    if (led3 !== 3'b100) begin
      n_fail++; $display("FAIL addr_valid got=%b exp=100", led3);
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_burst();
    test_zero_cfg();
    test_rewrite();
    test_back_to_back();
    test_async_reset();
    test_addr_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
